// File: rtl/pipe_arb_pkg.sv
// ============================================================================
//  pipe_arb_pkg
//  Shared types and helpers for the round-robin pipeline arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Modulo-n increment that also handles non-power-of-2 n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
//  rr_priority_pick
//  Rotating priority encoder: first set request at or after ptr, mod NUM_REQ.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_priority_pick
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic                       found_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IDXW = $clog2(NUM_REQ);

  int cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = int'(ptr_i);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_o && req_i[cand[IDXW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDXW-1:0];
      end
      cand = rr_next(cand, NUM_REQ);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_pipeline_arbiter.sv
// ============================================================================
//  rr_pipeline_arbiter
//  N requesters share one registered valid/ready stage; round-robin with
//  a per-grant burst limit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pipeline_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    out_src
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = $clog2(MAX_BURST + 1);

  arb_state_t            state_q;
  logic [IDXW-1:0]       ptr_q;
  logic [IDXW-1:0]       owner_q;
  logic [CW-1:0]         burst_cnt_q;
  logic [CW-1:0]         burst_cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDXW-1:0]       src_q;
  logic                  valid_q;

  logic                  load_en;
  logic                  pick_found;
  logic [IDXW-1:0]       pick_idx;
  logic                  xfer;
  logic [IDXW-1:0]       xfer_idx;
  logic [IDXW-1:0]       owner_inc_d;
  logic [IDXW-1:0]       grant_inc_d;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (in_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign load_en     = !valid_q || out_ready;
  assign burst_cnt_d = burst_cnt_q + CW'(1);
  assign owner_inc_d = IDXW'(rr_next(int'(owner_q), NUM_REQ));
  assign grant_inc_d = IDXW'(rr_next(int'(pick_idx), NUM_REQ));

  // Ready is withheld during reset so nothing handshakes into a stage being cleared.
  always_comb begin
    xfer     = 1'b0;
    xfer_idx = '0;
    if (!reset && load_en) begin
      if (state_q == IDLE) begin
        xfer     = pick_found;
        xfer_idx = pick_idx;
      end else begin
        xfer     = in_valid[owner_q];
        xfer_idx = owner_q;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[xfer_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      src_q       <= '0;
    end else if (load_en) begin
      valid_q <= xfer;
      if (xfer) begin
        data_q <= in_data[xfer_idx*DATA_WIDTH +: DATA_WIDTH];
        src_q  <= xfer_idx;
      end
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            if (MAX_BURST == 1) begin
              ptr_q <= grant_inc_d;
            end else begin
              owner_q     <= pick_idx;
              burst_cnt_q <= CW'(1);
              state_q     <= OWN;
            end
          end
        end
        OWN: begin
          // Burst exhausted or owner went idle: hand priority to the next index.
          if (!in_valid[owner_q] || burst_cnt_d == CW'(MAX_BURST)) begin
            state_q <= IDLE;
            ptr_q   <= owner_inc_d;
          end else begin
            burst_cnt_q <= burst_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;

endmodule

`default_nettype wire
